// File: rtl/joypad_pkg.sv
`default_nettype none
// ============================================================================
// joypad_pkg : shared types, button layout and pad-side protocol helper for
//              the NES controller poller.
// Revision    : 1.0  initial release
// ============================================================================
package joypad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STROBE = 3'd1,
        SETTLE = 3'd2,
        PULSE  = 3'd3,
        DONE   = 3'd4
    } joy_state_e;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Pad side: strobe loads the button byte, bit0 drives the data line, and
    // every falling clock edge shifts toward bit0 while ones fill from the top.
    function automatic logic [NUM_BUTTONS-1:0] pad_shift(input logic [NUM_BUTTONS-1:0] sr);
        return {1'b1, sr[NUM_BUTTONS-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/joypad_reader_if.sv
`default_nettype none
// ============================================================================
// joypad_reader_if : poll handshake, pad wiring and result bus of the reader.
// Revision         : 1.0  initial release
// ============================================================================
interface joypad_reader_if;
    import joypad_pkg::*;

    logic                   start;
    logic                   joy_strobe;
    logic [1:0]             joy_clock;
    logic [1:0]             joy_data;
    logic [NUM_BUTTONS-1:0] buttons1;
    logic [NUM_BUTTONS-1:0] buttons2;
    logic                   valid;
    logic                   busy;

    // slave = the reader itself, master = host core plus the pads
    modport slave (
        input  start, joy_data,
        output joy_strobe, joy_clock, buttons1, buttons2, valid, busy
    );

    modport master (
        output start, joy_data,
        input  joy_strobe, joy_clock, buttons1, buttons2, valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/joypad_timer.sv
`default_nettype none
// ============================================================================
// joypad_timer : reloadable down-counter, terminal count when it reaches zero.
// Revision     : 1.0  initial release
// ============================================================================
module joypad_timer #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_tc
);

    logic [WIDTH-1:0] r_cnt;

    // Parks at zero when not reloaded, so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/joypad_reader.sv
`default_nettype none
// ============================================================================
// joypad_reader : NES controller poller. Strobes both pads, clocks out eight
//                 bits each and publishes both button bytes with a valid pulse.
// Revision      : 1.0  initial release
// ============================================================================
module joypad_reader
    import joypad_pkg::*;
#(
    parameter int CLK_DIV         = 4,
    parameter int STROBE_LEN      = 4,
    parameter int DATA_ACTIVE_LOW = 0
) (
    input  wire logic      clk,
    input  wire logic      reset,
    joypad_reader_if.slave bus
);

    localparam int c_CNT_MAX = (CLK_DIV > STROBE_LEN) ? CLK_DIV : STROBE_LEN;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_STROBE_LOAD = c_CNT_W'(STROBE_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LOAD   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [1:0]         c_DATA_XOR    = (DATA_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
    localparam logic [2:0]         c_LAST_BIT    = 3'(NUM_BUTTONS - 1);

    localparam logic [2:0] c_IDLE   = IDLE;
    localparam logic [2:0] c_STROBE = STROBE;
    localparam logic [2:0] c_SETTLE = SETTLE;
    localparam logic [2:0] c_PULSE  = PULSE;
    localparam logic [2:0] c_DONE   = DONE;

    logic [2:0]             r_state;
    logic [2:0]             r_bit_idx;
    logic [NUM_BUTTONS-1:0] r_sr1;
    logic [NUM_BUTTONS-1:0] r_sr2;
    logic [NUM_BUTTONS-1:0] r_buttons1;
    logic [NUM_BUTTONS-1:0] r_buttons2;
    logic                   r_strobe;
    logic [1:0]             r_clock;
    logic                   r_valid;
    logic                   r_busy;

    logic                   w_tc;
    logic                   w_tmr_load;
    logic [c_CNT_W-1:0]     w_tmr_val;
    logic [1:0]             w_data;
    logic                   w_last_bit;

    assign w_data     = bus.joy_data ^ c_DATA_XOR;
    assign w_last_bit = (r_bit_idx == c_LAST_BIT);

    // Every phase length is reloaded at the edge that enters the phase.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_HALF_LOAD;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_STROBE_LOAD;
                end
            end
            c_STROBE, c_SETTLE: begin
                w_tmr_load = w_tc;
            end
            c_PULSE: begin
                w_tmr_load = w_tc && !w_last_bit;
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    joypad_timer #(
        .WIDTH (c_CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_bit_idx  <= 3'd0;
            r_sr1      <= '0;
            r_sr2      <= '0;
            r_buttons1 <= '0;
            r_buttons2 <= '0;
            r_strobe   <= 1'b0;
            r_clock    <= 2'b00;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_state  <= c_STROBE;
                        r_strobe <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                c_STROBE: begin
                    if (w_tc) begin
                        r_strobe  <= 1'b0;
                        r_bit_idx <= 3'd0;
                        r_state   <= c_SETTLE;
                    end
                end
                c_SETTLE: begin
                    // Data has had a full half-period to settle since the
                    // last falling clock edge; first sample lands in bit7
                    // and ends up in bit0 after eight shifts.
                    if (w_tc) begin
                        r_sr1   <= {w_data[0], r_sr1[NUM_BUTTONS-1:1]};
                        r_sr2   <= {w_data[1], r_sr2[NUM_BUTTONS-1:1]};
                        r_clock <= 2'b11;
                        r_state <= c_PULSE;
                    end
                end
                c_PULSE: begin
                    if (w_tc) begin
                        r_clock <= 2'b00;
                        if (w_last_bit) begin
                            r_state <= c_DONE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_state   <= c_SETTLE;
                        end
                    end
                end
                c_DONE: begin
                    r_buttons1 <= r_sr1;
                    r_buttons2 <= r_sr2;
                    r_valid    <= 1'b1;
                    r_state    <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.joy_strobe = r_strobe;
    assign bus.joy_clock  = r_clock;
    assign bus.buttons1   = r_buttons1;
    assign bus.buttons2   = r_buttons2;
    assign bus.valid      = r_valid;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_joypad_reader.sv
`default_nettype none
// ============================================================================
// tb_joypad_reader : scoreboard bench for joypad_reader with pad models, three
//                    parameter sets (default, active-low data, fastest timing).
// Revision         : 1.0  initial release
// ============================================================================
module tb_joypad_reader;
    import joypad_pkg::*;

    typedef struct {
        int         dut;
        logic [7:0] b1;
        logic [7:0] b2;
        int         cyc;
        int         falls;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst_n = 3'b000;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sbq[$];
    exp_t       mon_e;

    logic       start_s  [3];
    logic [7:0] pre1     [3];
    logic [7:0] pre2     [3];
    logic       strobe_s [3];
    logic [1:0] clock_s  [3];
    logic [7:0] b1_s     [3];
    logic [7:0] b2_s     [3];
    logic       valid_s  [3];
    logic       busy_s   [3];
    int         falls_w  [3];
    logic [15:0] prev_b  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CD = (g == 2) ? 1 : 4;
        localparam int SL = (g == 2) ? 1 : 4;
        localparam int AL = (g == 1) ? 1 : 0;

        logic [7:0] pad1 = 8'hFF;
        logic [7:0] pad2 = 8'hFF;
        int         falls = 0;

        joypad_reader_if bus ();

        joypad_reader #(
            .CLK_DIV         (CD),
            .STROBE_LEN      (SL),
            .DATA_ACTIVE_LOW (AL)
        ) dut (
            .clk   (clk),
            .reset (rst_n[g]),
            .bus   (bus)
        );

        assign bus.start    = start_s[g];
        assign bus.joy_data = {pad2[0], pad1[0]};
        assign strobe_s[g]  = bus.joy_strobe;
        assign clock_s[g]   = bus.joy_clock;
        assign b1_s[g]      = bus.buttons1;
        assign b2_s[g]      = bus.buttons2;
        assign valid_s[g]   = bus.valid;
        assign busy_s[g]    = bus.busy;
        assign falls_w[g]   = falls;

        always @(posedge bus.joy_strobe or negedge bus.joy_clock[0]) begin
            if (bus.joy_strobe) begin
                pad1 = pre1[g];
                pad2 = pre2[g];
            end else begin
                pad1 = pad_shift(pad1);
                pad2 = pad_shift(pad2);
                falls++;
            end
        end
    end

    function automatic int lat_of(input int i);
        return (i == 2) ? 18 : 69;
    endfunction
    function automatic int sl_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction
    function automatic int cd_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each valid pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                prev_b[i] = {b1_s[i], b2_s[i]};
            end else begin
                chk($sformatf("clock_invariant%0d", i),
                    32'((strobe_s[i] && clock_s[i] != 2'b00) || (clock_s[i][0] != clock_s[i][1])), 0);
                if (valid_s[i]) begin
                    if (sbq.size() == 0) begin
                        chk($sformatf("unexpected_valid%0d", i), 1, 0);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("sb_dut", i, mon_e.dut);
                        chk("buttons1", b1_s[i], mon_e.b1);
                        chk("buttons2", b2_s[i], mon_e.b2);
                        chk("valid_cycle", cyc, mon_e.cyc);
                        chk("clock_falls", falls_w[i], mon_e.falls);
                    end
                end else begin
                    chk($sformatf("buttons_hold%0d", i), {b1_s[i], b2_s[i]}, prev_b[i]);
                end
                prev_b[i] = {b1_s[i], b2_s[i]};
            end
        end
    end

    task automatic poll(input int i, input logic [7:0] r1, input logic [7:0] r2,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input int repulse, input int tail);
        int   t0, k, hi, run, maxrun, xv, xs;
        logic busy_ok, ps;
        pre1[i] = r1;
        pre2[i] = r2;
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        t0 = cyc;
        sbq.push_back('{dut: i, b1: e1, b2: e2, cyc: t0 + lat_of(i), falls: falls_w[i] + 8});
        k = 0; hi = 0; run = 0; maxrun = 0; busy_ok = 1'b1;
        while (!valid_s[i] && k < 400) begin
            if (!busy_s[i]) busy_ok = 1'b0;
            if (strobe_s[i]) hi++;
            if (clock_s[i] != 2'b00) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            start_s[i] = (repulse != 0 && k == repulse);
            @(negedge clk);
            k++;
        end
        start_s[i] = 1'b0;
        chk("valid_seen", 32'(valid_s[i]), 1);
        chk("busy_during_poll", 32'(busy_ok && busy_s[i]), 1);
        chk("strobe_cycles", hi, sl_of(i));
        chk("clock_high_run", maxrun, cd_of(i));
        @(negedge clk);
        chk("busy_valid_after", {busy_s[i], valid_s[i]}, 0);
        xv = 0; xs = 0; ps = strobe_s[i];
        for (int n = 0; n < tail; n++) begin
            @(negedge clk);
            if (valid_s[i]) xv++;
            if (strobe_s[i] && !ps) xs++;
            ps = strobe_s[i];
        end
        if (tail > 0) chk("extra_activity", xv + xs, 0);
    endtask

    initial begin
        int   t0, fb, k, nv, rises, nvr;
        logic ps;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            pre1[i] = 8'hFF;
            pre2[i] = 8'hFF;
            prev_b[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        rst_n = 3'b111;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_ctrl", {strobe_s[i], clock_s[i], valid_s[i], busy_s[i]}, 0);
            chk("reset_buttons", {b1_s[i], b2_s[i]}, 0);
        end

        // Default timing, active-high data
        poll(0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0, 0);

        // Active-low data: raw FE means only A pressed
        poll(1, 8'hFE, 8'hFF, 8'h01, 8'h00, 0, 0);

        // start held high: two back-to-back polls, pad1 changes in between
        pre1[0] = 8'h01;
        pre2[0] = 8'h00;
        start_s[0] = 1'b1;
        @(negedge clk);
        t0 = cyc;
        fb = falls_w[0];
        sbq.push_back('{dut: 0, b1: 8'h01, b2: 8'h00, cyc: t0 + 69,  falls: fb + 8});
        sbq.push_back('{dut: 0, b1: 8'h80, b2: 8'h00, cyc: t0 + 139, falls: fb + 16});
        nv = 0; rises = 0; ps = 1'b1; k = 0;
        while (nv < 2 && k < 400) begin
            @(negedge clk);
            k++;
            if (strobe_s[0] && !ps) rises++;
            ps = strobe_s[0];
            if (valid_s[0]) begin
                nv++;
                if (nv == 1) pre1[0] = 8'h80;
                else start_s[0] = 1'b0;
            end
        end
        start_s[0] = 1'b0;
        chk("held_valid_count", nv, 2);
        chk("held_strobe_rises", rises, 1);
        @(negedge clk);

        // Second start while busy must be ignored
        poll(0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 10, 80);

        // Reset in the middle of a poll
        pre1[0] = 8'hFF;
        pre2[0] = 8'h81;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (30) @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        chk("midreset_ctrl", {strobe_s[0], clock_s[0], valid_s[0], busy_s[0]}, 0);
        chk("midreset_buttons", {b1_s[0], b2_s[0]}, 0);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        nvr = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (valid_s[0] || busy_s[0]) nvr++;
        end
        chk("no_valid_after_reset", nvr, 0);
        poll(0, 8'hFF, 8'h81, 8'hFF, 8'h81, 0, 0);

        // Fastest timing: CLK_DIV=1, STROBE_LEN=1
        poll(2, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 0, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/joypad_reader.md
Name: joypad_reader

Overview:
- Initiator side of the NES controller serial port. Drives strobe and per-port clock, samples two serial data lines, and assembles one 8-bit button byte per pad.
- Used on the host/FPGA side to poll real controllers, or the team's shift-register controller model, and hand parallel button state to the NES core joypad inputs.
- One poll is started by a request pulse. Results for both pads are published together, with a one-cycle valid pulse.

Parameters:
- CLK_DIV, 4, clk cycles per half-period of the serial clock (>=1)
- STROBE_LEN, 4, clk cycles the strobe is held high (>=1)
- DATA_ACTIVE_LOW, 0, 1 = invert joy_data before sampling (raw 4021 pads pull low when pressed)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (low = reset)
- start  input  1  poll request; sampled only in IDLE
- joy_strobe  output  1  latch strobe to both pads
- joy_clock  output  2  serial clock, bit0 = pad1, bit1 = pad2 (driven identically)
- joy_data  input  2  serial data, bit0 = pad1, bit1 = pad2; first bit = A
- buttons1  output  8  pad1 state, bit0 = A … bit7 = Right
- buttons2  output  8  pad2 state, same layout
- valid  output  1  one-cycle pulse when buttons1/2 update
- busy  output  1  high from start acceptance until the valid cycle, inclusive

Behaviour:
- Reset (reset low, async): state = IDLE, all counters 0. joy_strobe=0, joy_clock=2'b00, buttons1=buttons2=8'h00, valid=0, busy=0, shift registers cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE: if start=1 at a clock edge, go to STROBE. busy and joy_strobe go high at that same edge. start is ignored in every non-IDLE state (no queuing).
- STROBE: joy_strobe=1 for exactly STROBE_LEN cycles.
  - Then joy_strobe=0, go to SETTLE with bit_idx=0.
- SETTLE: joy_clock=00 for CLK_DIV cycles.
  - On the last cycle, sample: sr1 <= {d[0], sr1[7:1]}, sr2 <= {d[1], sr2[7:1]}, where d = joy_data (XOR all-ones if DATA_ACTIVE_LOW).
  - Go to PULSE.
- PULSE: joy_clock=11 for CLK_DIV cycles. The falling edge back to 00 advances the pad shift register.
  - On exit, if bit_idx==7 go to DONE; else bit_idx++ and go to SETTLE.
- DONE (one cycle):
  - buttons1<=sr1, buttons2<=sr2, valid<=1; busy stays 1 this cycle.
  - Next cycle: valid=0, busy=0, state IDLE.
  - start is accepted again from that IDLE cycle onward.
- Latency:
  - Let T = the edge at which start is accepted.
  - The valid pulse is at T + STROBE_LEN + 16*CLK_DIV + 1 cycles (defaults: T+69).
  - Back-to-back polls with start held high: period = STROBE_LEN + 16*CLK_DIV + 2 cycles.
- Eight clock pulses are issued per poll; the eighth is harmless to the pads.
- joy_clock bits are never high while joy_strobe is high.
- buttons1/2 hold their last value between polls and never change except in the valid cycle.
- Counters:
  - The half-period counter width is clog2(max(CLK_DIV, STROBE_LEN)+1).
  - bit_idx is 3 bits.
  - Counters reload, never free-run, so no wrap-around.
- Reset mid-poll: all of the above reset values apply immediately. No partial result is published. joy_strobe/joy_clock drop low asynchronously.

Decomposition:
- Shared package joypad_pkg:
  - state enum {IDLE, STROBE, SETTLE, PULSE, DONE}
  - button bit index constants BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7
  - NUM_BUTTONS=8
- The controller model used by the bench (strobe load, shift on falling clock edge) also belongs there as documentation of the protocol.
- One natural sub-module: joypad_timer, a reloadable down-counter with terminal-count output, shared by STROBE/SETTLE/PULSE.
- Per-pad shifters are inline.

Test Plan:
- Pads model preloaded 8'hA5 / 8'h3C, start pulse at T, defaults -> valid at exactly T+69; buttons1=8'hA5, buttons2=8'h3C; busy high T..T+69; exactly 8 falling joy_clock edges.
- DATA_ACTIVE_LOW=1, raw model bytes 8'hFE / 8'hFF -> buttons1=8'h01 (A only), buttons2=8'h00.
- start held high continuously, pad1 changes 8'h01 -> 8'h80 between polls -> valid pulses spaced 70 cycles; second result buttons1=8'h80; no extra strobe while busy.
- start pulsed again at T+10 (busy) -> ignored; single valid at T+69; joy_strobe high only cycles T..T+3.
- reset asserted low at T+30 mid-SETTLE, preloaded 8'hFF -> joy_clock=00, joy_strobe=0, buttons=00, no valid. After release, a new start yields buttons1=8'hFF at +69.
- CLK_DIV=1, STROBE_LEN=1 -> valid at T+18; each joy_clock high phase is exactly 1 cycle; result matches model 8'h5A.
